// File: rtl/support_buttons_pkg.sv
// Shared types for the front-panel button conditioner: per-button FSM states and button index map.
package support_pkg;

  typedef enum logic [1:0] {
    BTN_RELEASED,
    BTN_PRESS_PEND,
    BTN_PRESSED,
    BTN_RELEASE_PEND
  } btn_state_e;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_B = 1;
  localparam int unsigned BTN_C = 2;
  localparam int unsigned BTN_H = 3;

endpackage

// File: rtl/support_buttons_if.sv
// Button bundle between the board pins/consumers and the conditioner; master is the conditioner side.
interface support_buttons_if #(
  parameter int unsigned N = 4
) ();
  logic [N-1:0] button_in;
  logic [N-1:0] button_level;
  logic [N-1:0] button_press;
  logic [N-1:0] button_release;
  logic [N-1:0] button_long;
  logic         tick;

  modport master (
    input  button_in,
    output button_level, button_press, button_release, button_long, tick
  );

  modport slave (
    output button_in,
    input  button_level, button_press, button_release, button_long, tick
  );
endinterface

// File: rtl/support_buttons_debounce_one.sv
// One button: 2-flop synchronizer, debounce FSM on the shared tick, registered level/press/release/long.
// Long-press counting is built only when SUPPORT_BUTTONS_LONGPRESS_EN is defined.
module support_debounce_one
  import support_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 10
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
  , parameter int unsigned LONG_TICKS = 1000
`endif
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic button_raw,
  input  logic tick,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
  localparam int unsigned CW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] LONG_M1  = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_TICKS);
`else
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
`endif
  localparam logic [CW-1:0] STABLE_M1 = CW'(STABLE_TICKS - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          long_q, long_d;
`endif

  always_comb begin
    meta_d    = button_raw;
    sync_d    = meta_q;
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
    lcnt_d    = lcnt_q;
    long_d    = 1'b0;
`endif
    // A sync reversal is tested before the tick so it always cancels a pending transition.
    case (state_q)
      BTN_RELEASED: begin
        if (sync_q) begin
          state_d = BTN_PRESS_PEND;
          dcnt_d  = '0;
        end
      end
      BTN_PRESS_PEND: begin
        if (!sync_q) begin
          state_d = BTN_RELEASED;
          dcnt_d  = '0;
        end else if (tick) begin
          if (dcnt_q == STABLE_M1) begin
            state_d = BTN_PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + CW'(1);
          end
        end
      end
      BTN_PRESSED: begin
        if (!sync_q) begin
          state_d = BTN_RELEASE_PEND;
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
        end else if (tick && (lcnt_q != LONG_MAX)) begin
          // Saturating at LONG_TICKS is what limits long to one pulse per accepted press.
          lcnt_d = lcnt_q + CW'(1);
          long_d = (lcnt_q == LONG_M1);
`endif
        end
      end
      BTN_RELEASE_PEND: begin
        if (sync_q) begin
          state_d = BTN_PRESSED;
          dcnt_d  = '0;
        end else if (tick) begin
          if (dcnt_q == STABLE_M1) begin
            state_d   = BTN_RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
            dcnt_d    = '0;
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
            lcnt_d    = '0;
`endif
          end else begin
            dcnt_d = dcnt_q + CW'(1);
          end
        end
      end
      default: state_d = BTN_RELEASED;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= BTN_RELEASED;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
      lcnt_q    <= '0;
      long_q    <= 1'b0;
`endif
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
      lcnt_q    <= lcnt_d;
      long_q    <= long_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
  assign long_o    = long_q;
`else
  assign long_o    = 1'b0;
`endif

endmodule

// File: rtl/support_buttons.sv
// Front-panel button conditioner: shared debounce prescaler plus one debounce FSM per button.
// button_long is built only with SUPPORT_BUTTONS_LONGPRESS_EN defined; otherwise it is tied to 0.
module support_buttons
  import support_pkg::*;
#(
  parameter int unsigned NBUTTONS     = 4,
  parameter int unsigned TICK_DIV     = 4096,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic              sysclk,
  input  logic              reset_n,
  support_buttons_if.master btn
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  // An illegal parameter set silences the tick, so no button ever changes state.
  localparam bit CFG_OK = (TICK_DIV >= 2) && (STABLE_TICKS >= 1) && (LONG_TICKS > STABLE_TICKS);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  always_comb begin
    presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
    tick_d  = CFG_OK && (presc_d == PMAX);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  logic [NBUTTONS-1:0] level_w, press_w, release_w, long_w;

  for (genvar i = 0; i < NBUTTONS; i++) begin : g_btn
    support_debounce_one #(
      .STABLE_TICKS (STABLE_TICKS)
`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
      , .LONG_TICKS (LONG_TICKS)
`endif
    ) u_db (
      .sysclk     (sysclk),
      .reset_n    (reset_n),
      .button_raw (btn.button_in[i]),
      .tick       (tick_q),
      .level_o    (level_w[i]),
      .press_o    (press_w[i]),
      .release_o  (release_w[i]),
      .long_o     (long_w[i])
    );
  end

  assign btn.button_level   = level_w;
  assign btn.button_press   = press_w;
  assign btn.button_release = release_w;
  assign btn.button_long    = long_w;
  assign btn.tick           = tick_q;

endmodule

// File: tb/tb_support_buttons.sv
// Directed bench for support_buttons with TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8.
module tb_support_buttons;
  import support_pkg::*;

`ifdef SUPPORT_BUTTONS_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic sysclk;
  logic reset_n;
  int   cyc;
  int   t0;
  int   checks;
  int   passes;

  support_buttons_if #(.N(4)) bif ();

  support_buttons #(
    .NBUTTONS     (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .LONG_TICKS   (8)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .btn     (bif)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance until n edges have elapsed since reset release; sample 1 time unit after the edge.
  task automatic step_to(input int n);
    while (cyc - t0 < n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] b);
    bif.button_in = b;
    reset_n = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    t0 = cyc;
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] seen;
    int long_cnt, rel_cnt, press_at, long_at;
    checks = 0;
    passes = 0;
    t0 = 0;

    // Reset with all buttons held: outputs quiet, tick phase, simultaneous press.
    bif.button_in = 4'hF;
    reset_n = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    check("reset_outputs", {15'd0, bif.button_level, bif.button_press, bif.button_release,
                            bif.button_long, bif.tick}, 32'd0);
    reset_n = 1'b1;
    t0 = cyc;
    step_to(1);  check("tick_n1", bif.tick, 0);
    step_to(2);  check("tick_n2", bif.tick, 0);
    step_to(3);  check("tick_n3", bif.tick, 1);
    step_to(4);  check("tick_n4", bif.tick, 0);
    step_to(11); check("rst_level_pre", bif.button_level, 4'h0);
                 check("rst_press_pre", bif.button_press, 4'h0);
    step_to(12); check("rst_press", bif.button_press, 4'hF);
                 check("rst_level", bif.button_level, 4'hF);
    step_to(13); check("rst_press_end", bif.button_press, 4'h0);
    bif.button_in = 4'h0;
    step_to(27); check("rel_all_pre", bif.button_release, 4'h0);
                 check("rel_all_level_pre", bif.button_level, 4'hF);
    step_to(28); check("rel_all", bif.button_release, 4'hF);
                 check("rel_all_level", bif.button_level, 4'h0);

    // Clean press on bit r: accepted 12 edges after the input edge, other bits untouched.
    do_reset(4'h0);
    v = '0; v[BTN_R] = 1'b1;
    bif.button_in = v;
    step_to(11); check("r_press_early", {bif.button_press, bif.button_level}, 8'h00);
    step_to(12); check("r_press", bif.button_press, v);
                 check("r_level", bif.button_level, v);
    step_to(13); check("r_press_one_cycle", bif.button_press, 4'h0);
                 check("r_level_hold", bif.button_level, v);

    // Bounce on bit b every 5 cycles: never accepted.
    do_reset(4'h0);
    v = '0; v[BTN_B] = 1'b1;
    bif.button_in = v;
    seen = '0;
    for (int n = 1; n <= 60; n++) begin
      step_to(n);
      if ((n % 5 == 0) && (n < 40)) bif.button_in[BTN_B] = ~bif.button_in[BTN_B];
      if (n == 40) bif.button_in = '0;
      seen |= bif.button_press | bif.button_release | bif.button_level;
    end
    check("bounce_quiet", seen, 4'h0);

    // Long press on bit h with a one-tick glitch low: exactly one long pulse.
    do_reset(4'h0);
    v = '0; v[BTN_H] = 1'b1;
    bif.button_in = v;
    long_cnt = 0; rel_cnt = 0; press_at = -1; long_at = -1;
    for (int n = 1; n <= 100; n++) begin
      step_to(n);
      if (n == 60) bif.button_in = '0;
      if (n == 64) bif.button_in = v;
      if (bif.button_press[BTN_H] && press_at < 0) press_at = n;
      if (bif.button_long[BTN_H]) begin
        long_cnt++;
        if (long_at < 0) long_at = n;
      end
      if (bif.button_release != 4'h0) rel_cnt++;
    end
    check("h_press_at", press_at, 12);
    check("h_long_count", long_cnt, LONG_EN ? 1 : 0);
    check("h_long_at", long_at, LONG_EN ? 44 : -1);
    check("h_no_release", rel_cnt, 0);
    check("h_level_end", bif.button_level, v);

    // Bits r and c released together, then reset mid-release.
    do_reset(4'h0);
    v = '0; v[BTN_R] = 1'b1; v[BTN_C] = 1'b1;
    bif.button_in = v;
    step_to(12); check("rc_press", bif.button_press, v);
    step_to(13); bif.button_in = '0;
    step_to(27); check("rc_rel_pre", bif.button_release, 4'h0);
                 check("rc_level_pre", bif.button_level, v);
    step_to(28); check("rc_release", bif.button_release, v);
                 check("rc_level_low", bif.button_level, 4'h0);
    step_to(29); check("rc_release_end", bif.button_release, 4'h0);
    bif.button_in = v;
    step_to(44); check("rc_repress", bif.button_press, v);
    step_to(45); bif.button_in = '0;
    step_to(53); check("rc_mid_release", bif.button_level, v);
    reset_n = 1'b0;
    #1;
    check("rc_reset_now", {bif.button_level, bif.button_release, bif.button_press}, 12'h000);
    seen = '0;
    repeat (8) begin
      @(posedge sysclk);
      #1;
      seen |= bif.button_release | bif.button_level;
    end
    check("rc_reset_quiet", seen, 4'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
